// File: rtl/data_mem_controller.sv
// rtl/data_mem_controller.sv - byte-serializing data memory controller for ROB store commits and LSB load issues
//
// Ports:
//   clk, rst_n                  clock, asynchronous active-low reset
//   flush                       misprediction flush (aborts loads, never stores)
//   rob_store_enable/op/addr/val   committed store request pulse
//   lsb_load_enable/op/addr/id     speculative load request pulse
//   io_buffer_full              IO write buffer full; stalls writes into the 0x3xxxx window
//   ram_din                     RAM read byte, valid the cycle after its address
//   mem_busy                    transaction or pending load outstanding
//   mem_data_ready/mem_data/mem_id  one-cycle load result
//   ram_a/ram_dout/ram_wr       byte-wide RAM port
module data_mem_controller #(
    parameter int XLEN           = 32,
    parameter int ROB_SIZE_WIDTH = 4,
    parameter int INST_OP_WIDTH  = 6,
    parameter logic [INST_OP_WIDTH-1:0] OP_LB  = INST_OP_WIDTH'(10),
    parameter logic [INST_OP_WIDTH-1:0] OP_LH  = INST_OP_WIDTH'(11),
    parameter logic [INST_OP_WIDTH-1:0] OP_LW  = INST_OP_WIDTH'(12),
    parameter logic [INST_OP_WIDTH-1:0] OP_LBU = INST_OP_WIDTH'(13),
    parameter logic [INST_OP_WIDTH-1:0] OP_LHU = INST_OP_WIDTH'(14),
    parameter logic [INST_OP_WIDTH-1:0] OP_SB  = INST_OP_WIDTH'(15),
    parameter logic [INST_OP_WIDTH-1:0] OP_SH  = INST_OP_WIDTH'(16),
    parameter logic [INST_OP_WIDTH-1:0] OP_SW  = INST_OP_WIDTH'(17)
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      flush,
    input  logic                      rob_store_enable,
    input  logic [INST_OP_WIDTH-1:0]  rob_store_op,
    input  logic [XLEN-1:0]           rob_store_addr,
    input  logic [XLEN-1:0]           rob_store_val,
    input  logic                      lsb_load_enable,
    input  logic [INST_OP_WIDTH-1:0]  lsb_load_op,
    input  logic [XLEN-1:0]           lsb_load_addr,
    input  logic [ROB_SIZE_WIDTH-1:0] lsb_load_id,
    input  logic                      io_buffer_full,
    input  logic [7:0]                ram_din,
    output logic                      mem_busy,
    output logic                      mem_data_ready,
    output logic [XLEN-1:0]           mem_data,
    output logic [ROB_SIZE_WIDTH-1:0] mem_id,
    output logic [XLEN-1:0]           ram_a,
    output logic [7:0]                ram_dout,
    output logic                      ram_wr
);

    typedef enum logic [1:0] {IDLE, READ, WRITE} state_t;

    state_t                    state;
    // WRITE: k = bytes already issued with ram_wr=1.
    // READ:  k = cycle index within the load (1 in the first cycle after acceptance).
    logic [2:0]                k;
    logic [2:0]                t_n;
    logic [XLEN-1:0]           t_addr;
    logic [XLEN-1:0]           t_val;
    logic [INST_OP_WIDTH-1:0]  t_op;
    logic [ROB_SIZE_WIDTH-1:0] t_id;
    logic [31:0]               cap;

    logic                      p_valid;
    logic [INST_OP_WIDTH-1:0]  p_op;
    logic [XLEN-1:0]           p_addr;
    logic [ROB_SIZE_WIDTH-1:0] p_id;

    logic [XLEN-1:0]           wr_a;
    logic [7:0]                wr_byte;
    logic                      w_stall;
    logic                      acc_stall;
    logic                      start_rd;
    logic [XLEN-1:0]           rd_addr;
    logic [INST_OP_WIDTH-1:0]  rd_op;
    logic [ROB_SIZE_WIDTH-1:0] rd_id;
    logic [31:0]               cap_next;
    logic [XLEN-1:0]           load_result;

    function automatic logic [2:0] size_of(input logic [INST_OP_WIDTH-1:0] op);
        if (op == OP_LW || op == OP_SW)
            return 3'd4;
        else if (op == OP_LH || op == OP_LHU || op == OP_SH)
            return 3'd2;
        else if (op == OP_LB || op == OP_LBU || op == OP_SB)
            return 3'd1;
        else
            return 3'd4;
    endfunction

    always_comb begin
        wr_a      = t_addr + XLEN'(k);
        wr_byte   = 8'(t_val >> {k, 3'b000});
        // Stalls only hit the IO window; the decision is registered with the byte it governs.
        w_stall   = io_buffer_full && (wr_a[17:16] == 2'b11);
        acc_stall = io_buffer_full && (rob_store_addr[17:16] == 2'b11);

        // A load starts either straight from IDLE or from the pending slot once the store ends.
        start_rd  = ((state == IDLE) && !rob_store_enable && lsb_load_enable && !flush) ||
                    ((state == WRITE) && (k == t_n) && p_valid && !flush);
        rd_addr   = (state == WRITE) ? p_addr : lsb_load_addr;
        rd_op     = (state == WRITE) ? p_op   : lsb_load_op;
        rd_id     = (state == WRITE) ? p_id   : lsb_load_id;
    end

    // Byte for the address issued in cycle k-1 arrives now; merge it so the final byte
    // can be returned at the same edge it is captured.
    always_comb begin
        cap_next = cap;
        if (state == READ) begin
            case (k)
                3'd2:    cap_next[7:0]   = ram_din;
                3'd3:    cap_next[15:8]  = ram_din;
                3'd4:    cap_next[23:16] = ram_din;
                3'd5:    cap_next[31:24] = ram_din;
                default: ;
            endcase
        end
        if (t_op == OP_LB)
            load_result = {{(XLEN-8){cap_next[7]}}, cap_next[7:0]};
        else if (t_op == OP_LH)
            load_result = {{(XLEN-16){cap_next[15]}}, cap_next[15:0]};
        else if (t_op == OP_LBU)
            load_result = XLEN'(cap_next[7:0]);
        else if (t_op == OP_LHU)
            load_result = XLEN'(cap_next[15:0]);
        else if (t_op == OP_LW)
            load_result = XLEN'(cap_next);
        else
            load_result = '0;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state          <= IDLE;
            k              <= '0;
            t_n            <= '0;
            t_addr         <= '0;
            t_val          <= '0;
            t_op           <= '0;
            t_id           <= '0;
            cap            <= '0;
            p_valid        <= 1'b0;
            p_op           <= '0;
            p_addr         <= '0;
            p_id           <= '0;
            mem_busy       <= 1'b0;
            mem_data_ready <= 1'b0;
            mem_data       <= '0;
            mem_id         <= '0;
            ram_a          <= '0;
            ram_dout       <= '0;
            ram_wr         <= 1'b0;
        end else begin
            mem_data_ready <= 1'b0;
            case (state)
                IDLE: begin
                    if (rob_store_enable) begin
                        state    <= WRITE;
                        mem_busy <= 1'b1;
                        t_addr   <= rob_store_addr;
                        t_val    <= rob_store_val;
                        t_n      <= size_of(rob_store_op);
                        ram_a    <= rob_store_addr;
                        ram_dout <= rob_store_val[7:0];
                        ram_wr   <= !acc_stall;
                        k        <= acc_stall ? 3'd0 : 3'd1;
                        if (lsb_load_enable && !flush) begin
                            p_valid <= 1'b1;
                            p_op    <= lsb_load_op;
                            p_addr  <= lsb_load_addr;
                            p_id    <= lsb_load_id;
                        end
                    end
                end
                WRITE: begin
                    if (k == t_n) begin
                        state    <= IDLE;
                        mem_busy <= 1'b0;
                        ram_a    <= '0;
                        ram_dout <= '0;
                        ram_wr   <= 1'b0;
                        p_valid  <= 1'b0;
                    end else begin
                        ram_a    <= wr_a;
                        ram_dout <= wr_byte;
                        ram_wr   <= !w_stall;
                        if (!w_stall)
                            k <= k + 3'd1;
                    end
                    if (flush)
                        p_valid <= 1'b0;
                end
                READ: begin
                    if (flush) begin
                        state    <= IDLE;
                        mem_busy <= 1'b0;
                        ram_a    <= '0;
                    end else begin
                        cap <= cap_next;
                        if (k == t_n + 3'd1) begin
                            mem_data_ready <= 1'b1;
                            mem_data       <= load_result;
                            mem_id         <= t_id;
                            state          <= IDLE;
                            mem_busy       <= 1'b0;
                            ram_a          <= '0;
                        end else begin
                            ram_a <= (k < t_n) ? t_addr + XLEN'(k) : '0;
                            k     <= k + 3'd1;
                        end
                    end
                end
                default: state <= IDLE;
            endcase

            if (start_rd) begin
                state    <= READ;
                mem_busy <= 1'b1;
                t_addr   <= rd_addr;
                t_op     <= rd_op;
                t_id     <= rd_id;
                t_n      <= size_of(rd_op);
                k        <= 3'd1;
                cap      <= '0;
                ram_a    <= rd_addr;
                ram_dout <= '0;
                ram_wr   <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_data_mem_controller.sv
// tb/tb_data_mem_controller.sv - scoreboard bench for data_mem_controller
module tb_data_mem_controller;

    localparam logic [5:0] LB = 6'd10, LH = 6'd11, LW = 6'd12, LBU = 6'd13,
                           LHU = 6'd14, SB = 6'd15, SH = 6'd16, SW = 6'd17;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        flush = 1'b0;
    logic        rob_store_enable = 1'b0;
    logic [5:0]  rob_store_op = '0;
    logic [31:0] rob_store_addr = '0;
    logic [31:0] rob_store_val = '0;
    logic        lsb_load_enable = 1'b0;
    logic [5:0]  lsb_load_op = '0;
    logic [31:0] lsb_load_addr = '0;
    logic [3:0]  lsb_load_id = '0;
    logic        io_buffer_full = 1'b0;
    logic [7:0]  ram_din = 8'h00;
    logic        mem_busy;
    logic        mem_data_ready;
    logic [31:0] mem_data;
    logic [3:0]  mem_id;
    logic [31:0] ram_a;
    logic [7:0]  ram_dout;
    logic        ram_wr;

    int checks = 0;
    int errors = 0;

    logic [35:0] ld_q[$];   // {id, data}
    logic [39:0] wr_q[$];   // {addr, byte}
    logic [35:0] ld_e;
    logic [39:0] wr_e;
    logic [7:0]  ram_mem [logic [31:0]];

    data_mem_controller #(
        .XLEN(32), .ROB_SIZE_WIDTH(4), .INST_OP_WIDTH(6),
        .OP_LB(LB), .OP_LH(LH), .OP_LW(LW), .OP_LBU(LBU),
        .OP_LHU(LHU), .OP_SB(SB), .OP_SH(SH), .OP_SW(SW)
    ) dut (
        .clk(clk), .rst_n(rst_n), .flush(flush),
        .rob_store_enable(rob_store_enable), .rob_store_op(rob_store_op),
        .rob_store_addr(rob_store_addr), .rob_store_val(rob_store_val),
        .lsb_load_enable(lsb_load_enable), .lsb_load_op(lsb_load_op),
        .lsb_load_addr(lsb_load_addr), .lsb_load_id(lsb_load_id),
        .io_buffer_full(io_buffer_full), .ram_din(ram_din),
        .mem_busy(mem_busy), .mem_data_ready(mem_data_ready),
        .mem_data(mem_data), .mem_id(mem_id),
        .ram_a(ram_a), .ram_dout(ram_dout), .ram_wr(ram_wr)
    );

    always #5 clk = ~clk;

    function automatic logic [7:0] init_byte(input logic [31:0] a);
        case (a)
            32'h0000_1000: return 8'h11;
            32'h0000_1001: return 8'h22;
            32'h0000_1002: return 8'h33;
            32'h0000_1003: return 8'h44;
            32'h0000_2000: return 8'h80;
            32'h0000_2010: return 8'hFE;
            32'h0000_2011: return 8'hFF;
            default:       return a[7:0] ^ 8'h5A;
        endcase
    endfunction

    // Byte-wide synchronous RAM
    always @(posedge clk) begin
        if (ram_wr)
            ram_mem[ram_a] = ram_dout;
        ram_din <= ram_mem.exists(ram_a) ? ram_mem[ram_a] : init_byte(ram_a);
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Scoreboard: every load result and every RAM write must match the head of its queue.
    always @(negedge clk) begin
        if (rst_n && mem_data_ready) begin
            if (ld_q.size() == 0)
                check("unexpected_ready", 64'd1, 64'd0);
            else begin
                ld_e = ld_q.pop_front();
                check("load_data", 64'(mem_data), 64'(ld_e[31:0]));
                check("load_id", 64'(mem_id), 64'(ld_e[35:32]));
            end
        end
        if (rst_n && ram_wr) begin
            if (wr_q.size() == 0)
                check("unexpected_write", 64'(ram_a), 64'hFFFF_FFFF_FFFF_FFFF);
            else begin
                wr_e = wr_q.pop_front();
                check("write_addr", 64'(ram_a), 64'(wr_e[39:8]));
                check("write_data", 64'(ram_dout), 64'(wr_e[7:0]));
            end
        end
    end

    task automatic run_load(input logic [5:0] op, input logic [31:0] a, input logic [3:0] id,
                            input logic [31:0] exp, input int lat);
        int n;
        ld_q.push_back({id, exp});
        lsb_load_enable = 1'b1;
        lsb_load_op     = op;
        lsb_load_addr   = a;
        lsb_load_id     = id;
        tick();
        lsb_load_enable = 1'b0;
        n = 0;
        while (!mem_data_ready && n < 20) begin
            tick();
            n++;
        end
        check("load_done", 64'(mem_data_ready), 64'd1);
        check("load_latency", 64'(n), 64'(lat));
        tick();
    endtask

    initial begin
        // Reset state
        tick();
        tick();
        check("reset_outputs", {mem_busy, mem_data_ready, mem_data, mem_id, ram_a, ram_dout, ram_wr}, 64'd0);
        rst_n = 1'b1;

        // LW 0x1000 id 5: cycle-accurate address and result timing
        ld_q.push_back({4'd5, 32'h4433_2211});
        lsb_load_enable = 1'b1; lsb_load_op = LW; lsb_load_addr = 32'h1000; lsb_load_id = 4'd5;
        for (int c = 1; c <= 7; c++) begin
            tick();
            lsb_load_enable = 1'b0;
            check($sformatf("lw_ram_a_c%0d", c), 64'(ram_a), (c <= 4) ? 64'(32'h1000 + c - 1) : 64'd0);
            check($sformatf("lw_ready_c%0d", c), 64'(mem_data_ready), (c == 6) ? 64'd1 : 64'd0);
            check($sformatf("lw_busy_c%0d", c), 64'(mem_busy), (c <= 5) ? 64'd1 : 64'd0);
            check($sformatf("lw_wr_c%0d", c), 64'(ram_wr), 64'd0);
        end

        // Sign and zero extension, plus address wrap
        run_load(LB,  32'h2000, 4'd1, 32'hFFFF_FF80, 2);
        run_load(LBU, 32'h2000, 4'd2, 32'h0000_0080, 2);
        run_load(LH,  32'h2010, 4'd3, 32'hFFFF_FFFE, 3);
        run_load(LHU, 32'h2010, 4'd4, 32'h0000_FFFE, 3);
        run_load(LW,  32'hFFFF_FFFE, 4'd6, 32'h5B5A_A5A4, 5);

        // SW 0xDEADBEEF at 0x0FFE; a load pulse while busy must be ignored
        wr_q.push_back({32'h0FFE, 8'hEF});
        wr_q.push_back({32'h0FFF, 8'hBE});
        wr_q.push_back({32'h1000, 8'hAD});
        wr_q.push_back({32'h1001, 8'hDE});
        rob_store_enable = 1'b1; rob_store_op = SW; rob_store_addr = 32'h0FFE; rob_store_val = 32'hDEAD_BEEF;
        for (int c = 1; c <= 5; c++) begin
            tick();
            rob_store_enable = 1'b0;
            lsb_load_enable = (c == 2);
            lsb_load_op = LB; lsb_load_addr = 32'h2000; lsb_load_id = 4'd8;
            check($sformatf("sw_wr_c%0d", c), 64'(ram_wr), (c <= 4) ? 64'd1 : 64'd0);
            check($sformatf("sw_busy_c%0d", c), 64'(mem_busy), (c <= 4) ? 64'd1 : 64'd0);
            check($sformatf("sw_ram_a_c%0d", c), 64'(ram_a), (c <= 4) ? 64'(32'h0FFE + c - 1) : 64'd0);
        end
        lsb_load_enable = 1'b0;
        tick();
        check("sw_no_ready", 64'(mem_data_ready), 64'd0);

        // Simultaneous SB to IO window (3 stall cycles) and LW id 2 into the pending slot
        wr_q.push_back({32'h0003_0000, 8'hAA});
        ld_q.push_back({4'd2, 32'h4433_DEAD});
        io_buffer_full = 1'b1;
        rob_store_enable = 1'b1; rob_store_op = SB; rob_store_addr = 32'h0003_0000; rob_store_val = 32'h0000_00AA;
        lsb_load_enable = 1'b1; lsb_load_op = LW; lsb_load_addr = 32'h1000; lsb_load_id = 4'd2;
        for (int c = 1; c <= 11; c++) begin
            tick();
            rob_store_enable = 1'b0;
            lsb_load_enable = 1'b0;
            check($sformatf("io_wr_c%0d", c), 64'(ram_wr), (c == 4) ? 64'd1 : 64'd0);
            check($sformatf("io_ram_a_c%0d", c), 64'(ram_a),
                  (c <= 4) ? 64'h0003_0000 : (c <= 8) ? 64'(32'h1000 + c - 5) : 64'd0);
            check($sformatf("io_busy_c%0d", c), 64'(mem_busy), (c <= 9) ? 64'd1 : 64'd0);
            check($sformatf("io_ready_c%0d", c), 64'(mem_data_ready), (c == 10) ? 64'd1 : 64'd0);
            if (c == 3)
                io_buffer_full = 1'b0;
        end

        // Load pulse together with flush is dropped
        flush = 1'b1;
        lsb_load_enable = 1'b1; lsb_load_op = LW; lsb_load_addr = 32'h1000; lsb_load_id = 4'd11;
        tick();
        flush = 1'b0;
        lsb_load_enable = 1'b0;
        check("flush_drop_busy", 64'(mem_busy), 64'd0);

        // LW aborted by flush in cycle 3, then LB accepted in cycle 4
        lsb_load_enable = 1'b1; lsb_load_op = LW; lsb_load_addr = 32'h1000; lsb_load_id = 4'd7;
        tick();
        lsb_load_enable = 1'b0;
        tick();
        tick();
        flush = 1'b1;
        tick();
        flush = 1'b0;
        check("flush_busy_c4", 64'(mem_busy), 64'd0);
        check("flush_ram_a_c4", 64'(ram_a), 64'd0);
        check("flush_ready_c4", 64'(mem_data_ready), 64'd0);
        run_load(LB, 32'h2000, 4'd9, 32'hFFFF_FF80, 2);

        // Reset dropped in cycle 2 of an SW
        wr_q.push_back({32'h4000, 8'h78});
        rob_store_enable = 1'b1; rob_store_op = SW; rob_store_addr = 32'h4000; rob_store_val = 32'h1234_5678;
        tick();
        rob_store_enable = 1'b0;
        check("rst_sw_c1_wr", 64'(ram_wr), 64'd1);
        tick();
        #2;
        rst_n = 1'b0;
        #1;
        check("rst_async_outputs", {mem_busy, mem_data_ready, mem_data, mem_id, ram_a, ram_dout, ram_wr}, 64'd0);
        tick();
        tick();
        check("rst_held_outputs", {mem_busy, mem_data_ready, mem_data, mem_id, ram_a, ram_dout, ram_wr}, 64'd0);
        rst_n = 1'b1;
        run_load(LW, 32'h1000, 4'd4, 32'h4433_DEAD, 5);

        tick();
        check("load_queue_empty", 64'(ld_q.size()), 64'd0);
        check("write_queue_empty", 64'(wr_q.size()), 64'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
